// File: rtl/mem_wait_responder.sv
// mem_wait_responder: single-request memory responder with programmable wait states,
// a one-cycle Ready/Err completion pulse and registered read data.
module mem_wait_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 8,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              We,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] RData,
  output logic              Ready,
  output logic              Err,
  output logic              Busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q, err_q, bad, fire;
  logic [DEPTH_W-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [2**DEPTH_W];
  assign bad   = (|Addr[1:0]) || (|Addr[ADDR_W-1:DEPTH_W+2]);
  assign fire  = (state == WAIT) && (cnt == 4'd1);
  assign Ready = (state == RESP);
  assign Err   = (state == RESP) && err_q;
  assign Busy  = (state != IDLE);
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (Req ? WAIT : IDLE) : fire ? RESP : (state == WAIT) ? WAIT : IDLE;
  end
  // Rejected requests also spend one WAIT cycle, so their response follows the acceptance edge by one.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      RData   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && Req) begin
        we_q    <= We;
        err_q   <= bad;
        idx_q   <= Addr[DEPTH_W+1:2];
        wdata_q <= WData;
        cnt     <= bad ? 4'd1 : We ? 4'(WR_WAIT) : 4'(RD_WAIT);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (fire && !err_q && !we_q) RData <= mem[idx_q];
    end
  end
  always_ff @(posedge Clk) begin
    if (fire && !err_q && we_q) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_mem_wait_responder.sv
// tb_mem_wait_responder: randomized and directed checks against a word-array reference model.
module tb_mem_wait_responder;
  localparam int RW = 2;
  localparam int WW = 2;
  logic Clk = 0, Reset = 1, Req = 0, We = 0;
  logic [31:0] Addr = 0, WData = 0, RData;
  logic Ready, Err, Busy;
  int tests = 0, fails = 0;
  logic [31:0] mem_m [256];
  bit known [256];
  logic [31:0] rdata_m = 0;

  mem_wait_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_W(8), .RD_WAIT(RW), .WR_WAIT(WW)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Addr(Addr), .WData(WData),
    .RData(RData), .Ready(Ready), .Err(Err), .Busy(Busy));

  always #5 Clk = ~Clk;

  // One complete access; response latency, error flag and read data come from the model.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d);
    bit bad = (a[1:0] != 0) || (a[31:10] != 0);
    int n = bad ? 1 : (we ? WW : RW);
    int k = 0;
    bit err_seen = 0;
    @(negedge Clk); Req = 1; We = we; Addr = a; WData = d;
    @(posedge Clk); #1;
    Req = 0; We = 1'($urandom); Addr = $urandom; WData = $urandom;
    tests++;
    if (Busy !== 1'b1) begin fails++; $display("FAIL busy_after_accept a=%h got=%b exp=1", a, Busy); end
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(posedge Clk); #1;
      if (Ready === 1'b1) begin k = i; err_seen = Err; end
      else if (Err !== 1'b0) begin tests++; fails++; $display("FAIL err_without_ready a=%h got=%b exp=0", a, Err); end
    end
    if (!bad) begin
      if (we) begin mem_m[a[9:2]] = d; known[a[9:2]] = 1; end
      else rdata_m = mem_m[a[9:2]];
    end
    tests++;
    if (k != n) begin fails++; $display("FAIL latency a=%h we=%b got=%0d exp=%0d", a, we, k, n); end
    tests++;
    if (err_seen !== bad) begin fails++; $display("FAIL err_flag a=%h got=%b exp=%b", a, err_seen, bad); end
    tests++;
    if (RData !== rdata_m) begin fails++; $display("FAIL rdata a=%h got=%h exp=%h", a, RData, rdata_m); end
    @(posedge Clk); #1;
    tests++;
    if (Ready !== 1'b0 || Busy !== 1'b0 || Err !== 1'b0) begin
      fails++; $display("FAIL back_to_idle a=%h got=%b%b%b exp=000", a, Ready, Busy, Err);
    end
  endtask

  task automatic test_reset;
    Reset = 1;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset = 0; Req = 0;
    rdata_m = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      tests++;
      if (RData !== 0 || Ready !== 0 || Err !== 0 || Busy !== 0) begin
        fails++; $display("FAIL reset_idle cyc=%0d got=%h/%b%b%b exp=0/000", i, RData, Ready, Err, Busy);
      end
    end
  endtask

  task automatic test_write_read;
    access(1, 32'h10, 32'hDEADBEEF);
    access(0, 32'h10, 32'h0);
  endtask

  task automatic test_misaligned;
    access(0, 32'h13, 32'h0);
    access(0, 32'h10, 32'h0);
  endtask

  task automatic test_out_of_range;
    access(1, 32'h0, 32'h0);
    access(1, 32'h400, 32'h1);
    access(0, 32'h0, 32'h0);
  endtask

  task automatic test_req_held;
    int cyc[$];
    logic [31:0] dat[$];
    access(1, 32'h20, 32'hA1A1A1A1);
    access(1, 32'h24, 32'hB2B2B2B2);
    @(negedge Clk); Req = 1; We = 0; Addr = 32'h20;
    @(posedge Clk); #1;
    Addr = 32'h24;
    for (int i = 1; i <= 12; i++) begin
      @(posedge Clk); #1;
      if (Ready === 1'b1) begin cyc.push_back(i); dat.push_back(RData); end
      if (i == 4) Req = 0;
    end
    rdata_m = mem_m[9];
    tests++;
    if (cyc.size() != 2) begin fails++; $display("FAIL held_ready_count got=%0d exp=2", cyc.size()); end
    else begin
      tests++;
      if (cyc[0] != 2 || cyc[1] != 6) begin
        fails++; $display("FAIL held_ready_timing got=%0d,%0d exp=2,6", cyc[0], cyc[1]);
      end
      tests++;
      if (dat[0] !== mem_m[8] || dat[1] !== mem_m[9]) begin
        fails++; $display("FAIL held_data got=%h,%h exp=%h,%h", dat[0], dat[1], mem_m[8], mem_m[9]);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    int rdy = 0;
    access(1, 32'h30, 32'h0);
    @(negedge Clk); Req = 1; We = 1; Addr = 32'h30; WData = 32'h55;
    @(posedge Clk); #1; Req = 0;
    @(negedge Clk); Reset = 1; #1;
    tests++;
    if (Busy !== 0 || RData !== 0) begin fails++; $display("FAIL reset_abort got=%b/%h exp=0/0", Busy, RData); end
    @(negedge Clk); Reset = 0;
    rdata_m = 0;
    for (int i = 0; i < 6; i++) begin @(posedge Clk); #1; if (Ready === 1'b1) rdy++; end
    tests++;
    if (rdy != 0) begin fails++; $display("FAIL reset_no_ready got=%0d exp=0", rdy); end
    access(0, 32'h30, 32'h0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      int r = $urandom_range(0, 9);
      int w = $urandom_range(0, 15);
      logic [31:0] a;
      logic we;
      if (r == 0) begin a = {22'd0, 8'(w), 2'($urandom_range(1, 3))}; we = 1'($urandom); end
      else if (r == 1) begin a = 32'h400 + 32'($urandom_range(0, 1000)) * 4; we = 1'($urandom); end
      else begin a = 32'(w) << 2; we = !known[w] || 1'($urandom); end
      access(we, a, $urandom);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_misaligned;
    test_out_of_range;
    test_req_held;
    test_reset_mid_write;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
